// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM encoding, default widths
// and the buffered-entry layout.
package fetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs for the decode stage.
// clear empties it in one edge; contents are only zeroed by reset.
module ifetch_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  output logic [CW-1:0]     count,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr
);

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding req/ack read at a time, results buffered
// in a small FIFO toward decode; flush kills buffered and in-flight fetches.
module ifetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_take,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready,
  output fetch_state_t      dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: a beat transfers on any edge where valid/req and ready/ack are
  // both high; req and its address hold steady until ack, and id_* hold steady
  // while id_valid is high and id_ready is low (flush excepted).

  fetch_state_t  state, state_next;
  logic [CW-1:0] count, count_next;
  logic          push, pop, issue;

  assign push       = (state == REQ) && imem_ack && !flush;
  assign pop        = id_valid && id_ready && !flush;
  assign count_next = count + CW'(push) - CW'(pop);
  // Space is reserved at issue time, so a returning read can always be pushed.
  assign issue      = !reset && !flush && (count_next < CW'(DEPTH)) &&
                      ((state == IDLE) || ((state == REQ) && imem_ack));
  assign pc_take    = issue;
  assign imem_req   = (state != IDLE);
  assign dbg_state  = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue) state_next = REQ;
      REQ: begin
        if (imem_ack)   state_next = issue ? REQ : IDLE;
        else if (flush) state_next = DROP;
      end
      DROP: if (imem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_addr <= '0;
    end else begin
      state <= state_next;
      if (issue) imem_addr <= pc_in;
    end
  end

  ifetch_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (push),
    .pop        (pop),
    .push_pc    (imem_addr),
    .push_instr (imem_rdata),
    .count      (count),
    .head_valid (id_valid),
    .head_pc    (id_pc),
    .head_instr (id_instr)
  );

endmodule
